// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory stage: opcode one-hot bit positions,
// load/store funct3 encodings, FSM state encoding and exception bit indices.
// Imported by mem_access and mem_lane_align.
package mem_access_pkg;

  // Widths of the one-hot opcode and exception vectors that travel down the pipe
  localparam int OPCODE_WIDTH    = 11;
  localparam int EXCEPTION_WIDTH = 4;

  // One-hot opcode bit positions
  localparam int OP_LUI    = 0;
  localparam int OP_AUIPC  = 1;
  localparam int OP_JAL    = 2;
  localparam int OP_JALR   = 3;
  localparam int OP_BRANCH = 4;
  localparam int OP_LOAD   = 5;
  localparam int OP_STORE  = 6;
  localparam int OP_IMM    = 7;
  localparam int OP_OP     = 8;
  localparam int OP_FENCE  = 9;
  localparam int OP_SYSTEM = 10;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Exception vector bit indices raised by this stage
  localparam int EXC_LOAD_ADDR_MISALIGNED  = 2;
  localparam int EXC_STORE_ADDR_MISALIGNED = 3;

  // Memory-stage FSM states
  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  // True when funct3 names a load this stage understands
  function automatic logic load_f3_valid(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // True when funct3 names a store this stage understands
  function automatic logic store_f3_valid(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for stores and extract/extend for loads.
// Zero latency; no state, no handshake.
// Byte enables follow access size for loads too so the bus sees the real footprint.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_word_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o
);

  logic [31:0] load_shift;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  assign load_shift = load_word_i >> {addr_lo_i, 3'b000};
  assign load_byte  = load_shift[7:0];
  assign load_half  = addr_lo_i[1] ? load_word_i[31:16] : load_word_i[15:0];

  // Store side: byte enables, replicated write data and alignment status by size
  always_comb begin
    be_o         = 4'b0000;
    wdata_o      = store_data_i;
    misaligned_o = 1'b0;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        be_o         = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o      = {2{store_data_i[15:0]}};
        misaligned_o = addr_lo_i[0];
      end
      2'b10: begin
        be_o         = 4'b1111;
        misaligned_o = |addr_lo_i;
      end
      default: begin
        be_o = 4'b0000;
      end
    endcase
  end

  // Load side: pick the addressed byte/half and sign- or zero-extend by funct3[2]
  always_comb begin
    load_data_o = load_word_i;
    case (funct3_i)
      F3_LB:   load_data_o = {{24{load_byte[7]}}, load_byte};
      F3_LBU:  load_data_o = {24'h000000, load_byte};
      F3_LH:   load_data_o = {{16{load_half[15]}}, load_half};
      F3_LHU:  load_data_o = {16'h0000, load_half};
      default: load_data_o = load_word_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory pipeline stage: one data-bus request per load/store, results to writeback.
// Request leaves one cycle after the instruction arrives; min occupancy 3 cycles.
// Stalls upstream until the bus acks; MEM_MISALIGN_TRAP_EN turns misaligned accesses into traps.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int DMEM_AW = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [OPCODE_WIDTH-1:0]    prev_opcode_type,
  input  logic [EXCEPTION_WIDTH-1:0] prev_exception,
  input  logic [31:0]                prev_alu_result,
  input  logic [31:0]                prev_rs2_data,
  input  logic [2:0]                 prev_funct3,
  input  logic [4:0]                 prev_rd,
  input  logic [31:0]                prev_rd_wdata,
  input  logic                       prev_rd_valid,
  input  logic                       prev_rd_w_en,
  input  logic [31:0]                prev_pc,
  input  logic                       prev_stall_from_alu,
  input  logic                       prev_clk_en,
  input  logic                       prev_stall,
  input  logic                       force_stall,
  input  logic                       prev_flush,
  output logic                       dmem_req,
  output logic                       dmem_we,
  output logic [DMEM_AW-1:0]         dmem_addr,
  output logic [31:0]                dmem_wdata,
  output logic [3:0]                 dmem_be,
  input  logic                       dmem_ack,
  input  logic [31:0]                dmem_rdata,
  output logic [OPCODE_WIDTH-1:0]    opcode_type,
  output logic [EXCEPTION_WIDTH-1:0] exception,
  output logic [4:0]                 rd,
  output logic [31:0]                rd_wdata,
  output logic                       rd_valid,
  output logic                       rd_w_en,
  output logic [31:0]                pc,
  output logic                       clk_en,
  output logic                       stall,
  output logic                       flush
);

  // Decode of the incoming instruction
  logic is_load, is_store, mem_op, f3_ok, access_ok, stall_bit, mem_done;
  logic [EXCEPTION_WIDTH-1:0] exc_add_d;

  // Lane helper outputs, used as next-state values for the bus registers
  logic [3:0]         be_d;
  logic [31:0]        wdata_d;
  logic [31:0]        load_d;
  logic               misaligned;
  logic [DMEM_AW-1:0] addr_d;

  // FSM and bus registers
  mem_state_e         state_q;
  logic               req_q, we_q;
  logic [DMEM_AW-1:0] addr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         be_q;
  logic [31:0]        load_q;
  logic               ld_q;      // completed access was a load with captured data
  logic               bad_q;     // access was refused (unknown funct3 or trapped)
  logic [EXCEPTION_WIDTH-1:0] exc_add_q;

  // Writeback-facing stage registers
  logic                       clk_en_q;
  logic                       flush_pend_q;
  logic [OPCODE_WIDTH-1:0]    opcode_q;
  logic [EXCEPTION_WIDTH-1:0] exception_q;
  logic [4:0]                 rd_q;
  logic [31:0]                rd_wdata_q;
  logic                       rd_valid_q;
  logic                       rd_w_en_q;
  logic [31:0]                pc_q;

  assign is_store = prev_opcode_type[OP_STORE];
  assign is_load  = prev_opcode_type[OP_LOAD] && !is_store;
  assign mem_op   = prev_clk_en && prev_stall_from_alu && (is_load || is_store);
  assign f3_ok    = is_store ? store_f3_valid(prev_funct3) : load_f3_valid(prev_funct3);
  assign addr_d   = {prev_alu_result[DMEM_AW-1:2], 2'b00};
  assign mem_done = (state_q == MEM_DONE);

`ifdef MEM_MISALIGN_TRAP_EN
  assign access_ok = f3_ok && !misaligned;

  // Misaligned half/word accesses become exceptions instead of bus cycles
  always_comb begin
    exc_add_d = '0;
    if (f3_ok && misaligned) begin
      if (is_store) exc_add_d[EXC_STORE_ADDR_MISALIGNED] = 1'b1;
      else          exc_add_d[EXC_LOAD_ADDR_MISALIGNED]  = 1'b1;
    end
  end
`else
  assign access_ok = f3_ok;
  assign exc_add_d = '0;
`endif

  // A memory op holds everything upstream until it reaches DONE
  assign stall     = prev_stall || force_stall || (mem_op && !mem_done);
  assign stall_bit = prev_stall || stall;
  assign flush     = prev_flush;

  mem_lane_align u_lane (
    .funct3_i     (prev_funct3),
    .addr_lo_i    (prev_alu_result[1:0]),
    .store_data_i (prev_rs2_data),
    .load_word_i  (dmem_rdata),
    .be_o         (be_d),
    .wdata_o      (wdata_d),
    .load_data_o  (load_d),
    .misaligned_o (misaligned)
  );

  // Bus FSM: issue once, hold until ack, then wait in DONE for the stage to advance
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= MEM_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      load_q    <= '0;
      ld_q      <= 1'b0;
      bad_q     <= 1'b0;
      exc_add_q <= '0;
    end else begin
      case (state_q)
        MEM_IDLE: begin
          // A flush arriving with the op does not stop the access from starting
          if (mem_op) begin
            ld_q      <= 1'b0;
            exc_add_q <= exc_add_d;
            if (access_ok) begin
              state_q <= MEM_WAIT;
              bad_q   <= 1'b0;
              req_q   <= 1'b1;
              we_q    <= is_store;
              addr_q  <= addr_d;
              be_q    <= be_d;
              wdata_q <= wdata_d;
            end else begin
              state_q <= MEM_DONE;
              bad_q   <= 1'b1;
            end
          end
        end
        MEM_WAIT: begin
          if (dmem_ack) begin
            state_q <= MEM_DONE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            if (!we_q) begin
              ld_q   <= 1'b1;
              load_q <= load_d;
            end
          end
        end
        MEM_DONE: begin
          if (!stall_bit) state_q <= MEM_IDLE;
        end
        default: state_q <= MEM_IDLE;
      endcase
    end
  end

  // Stage registers toward writeback, plus the valid/bubble/flush bookkeeping
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_en_q     <= 1'b0;
      flush_pend_q <= 1'b0;
      opcode_q     <= '0;
      exception_q  <= '0;
      rd_q         <= '0;
      rd_wdata_q   <= '0;
      rd_valid_q   <= 1'b0;
      rd_w_en_q    <= 1'b0;
      pc_q         <= '0;
    end else begin
      if (!stall_bit)       clk_en_q <= (prev_flush || flush_pend_q) ? 1'b0 : prev_clk_en;
      else if (!prev_stall) clk_en_q <= 1'b0;

      // Remember a flush seen while the access is in flight so its result is dropped
      flush_pend_q <= stall_bit && (flush_pend_q || (prev_flush && mem_op));

      if (!stall_bit && prev_clk_en) begin
        opcode_q    <= prev_opcode_type;
        exception_q <= prev_exception | (mem_done ? exc_add_q : {EXCEPTION_WIDTH{1'b0}});
        rd_q        <= prev_rd;
        rd_wdata_q  <= (mem_done && ld_q) ? load_q : prev_rd_wdata;
        rd_valid_q  <= (mem_done && ld_q) ? 1'b1 : prev_rd_valid;
        rd_w_en_q   <= prev_rd_w_en && !(mem_done && bad_q);
        pc_q        <= prev_pc;
      end
    end
  end

  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_wdata  = wdata_q;
  assign dmem_be     = be_q;
  assign clk_en      = clk_en_q;
  assign opcode_type = opcode_q;
  assign exception   = exception_q;
  assign rd          = rd_q;
  assign rd_wdata    = rd_wdata_q;
  assign rd_valid    = rd_valid_q;
  assign rd_w_en     = rd_w_en_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed-vector bench for mem_access: table of load/store cases plus
// hand-written sequences for reset, external stall, flush and pass-through.
module tb_mem_access;
  import mem_access_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [OPCODE_WIDTH-1:0]    prev_opcode_type = '0;
  logic [EXCEPTION_WIDTH-1:0] prev_exception = '0;
  logic [31:0] prev_alu_result = '0, prev_rs2_data = '0, prev_rd_wdata = '0, prev_pc = '0;
  logic [2:0]  prev_funct3 = '0;
  logic [4:0]  prev_rd = '0;
  logic prev_rd_valid = 0, prev_rd_w_en = 0, prev_stall_from_alu = 0, prev_clk_en = 0;
  logic prev_stall = 0, force_stall = 0, prev_flush = 0, dmem_ack = 0;
  logic [31:0] dmem_rdata = '0;

  logic dmem_req, dmem_we, rd_valid, rd_w_en, clk_en, stall, flush;
  logic [31:0] dmem_addr, dmem_wdata, rd_wdata, pc;
  logic [3:0]  dmem_be;
  logic [OPCODE_WIDTH-1:0]    opcode_type;
  logic [EXCEPTION_WIDTH-1:0] exception;
  logic [4:0] rd;

  mem_access #(.DMEM_AW(32)) dut (
    .clk(clk), .rstn(rstn),
    .prev_opcode_type(prev_opcode_type), .prev_exception(prev_exception),
    .prev_alu_result(prev_alu_result), .prev_rs2_data(prev_rs2_data),
    .prev_funct3(prev_funct3), .prev_rd(prev_rd), .prev_rd_wdata(prev_rd_wdata),
    .prev_rd_valid(prev_rd_valid), .prev_rd_w_en(prev_rd_w_en), .prev_pc(prev_pc),
    .prev_stall_from_alu(prev_stall_from_alu), .prev_clk_en(prev_clk_en),
    .prev_stall(prev_stall), .force_stall(force_stall), .prev_flush(prev_flush),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .opcode_type(opcode_type), .exception(exception),
    .rd(rd), .rd_wdata(rd_wdata), .rd_valid(rd_valid), .rd_w_en(rd_w_en),
    .pc(pc), .clk_en(clk_en), .stall(stall), .flush(flush)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h want=%08h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          dly;
    logic        fl;
    logic        e_req;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic        e_ce;
    logic [31:0] e_rdw;
    logic        e_rdv;
    logic        e_wen;
    logic [3:0]  e_exc;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input logic [31:0] rdt, input int dly,
                              input logic fl, input logic e_req, input logic [31:0] e_addr,
                              input logic [3:0] e_be, input logic [31:0] e_wd, input logic e_ce,
                              input logic [31:0] e_rdw, input logic e_rdv, input logic e_wen,
                              input logic [3:0] e_exc);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = a; v.sdata = sd; v.rdata = rdt; v.dly = dly; v.fl = fl;
    v.e_req = e_req; v.e_addr = e_addr; v.e_be = e_be; v.e_wd = e_wd; v.e_ce = e_ce;
    v.e_rdw = e_rdw; v.e_rdv = e_rdv; v.e_wen = e_wen; v.e_exc = e_exc;
    return v;
  endfunction

  localparam logic [31:0] PASS_WD = 32'h5555AAAA;
  localparam logic [3:0]  EXC_LD  = 4'b0100;
  localparam logic [3:0]  EXC_ST  = 4'b1000;

  vec_t vec [13];

  // Observed values from one table-driven access
  logic        o_stall0, o_req, o_we, o_held, o_tmo, o_ce, o_ce2, o_rdv, o_wen;
  logic [31:0] o_addr, o_wd, o_rdw;
  logic [3:0]  o_be, o_exc;

  task automatic drive_mem(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd);
    prev_opcode_type = '0;
    if (st) prev_opcode_type[OP_STORE] = 1'b1;
    else    prev_opcode_type[OP_LOAD]  = 1'b1;
    prev_funct3 = f3; prev_alu_result = a; prev_rs2_data = sd;
    prev_rd = 5'd9; prev_rd_wdata = PASS_WD; prev_rd_valid = 1'b0;
    prev_rd_w_en = !st; prev_pc = 32'h0000_1000; prev_exception = '0;
    prev_stall_from_alu = 1'b1; prev_clk_en = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    @(negedge clk);
    drive_mem(v.st, v.f3, v.addr, v.sdata);
    #1 o_stall0 = stall;
    @(negedge clk);
    o_req = dmem_req; o_addr = dmem_addr; o_be = dmem_be; o_wd = dmem_wdata; o_we = dmem_we;
    o_held = 1'b1;
    if (dmem_req) begin
      for (int i = 0; i < v.dly; i++) begin
        if (i == 0 && v.fl) begin
          prev_flush = 1'b1;
          #1 chk("flush_out", {31'b0, flush}, 32'd1);
        end
        @(negedge clk);
        prev_flush = 1'b0;
        o_held &= dmem_req && stall && (dmem_addr == o_addr) && (dmem_be == o_be);
      end
      dmem_ack = 1'b1; dmem_rdata = v.rdata;
      @(negedge clk);
      dmem_ack = 1'b0; dmem_rdata = 32'hDEAD_0000;
    end
    n = 0;
    while (stall && n < 20) begin
      @(negedge clk);
      n++;
    end
    o_tmo = stall;
    @(negedge clk);
    o_ce = clk_en; o_rdw = rd_wdata; o_rdv = rd_valid; o_wen = rd_w_en; o_exc = exception;
    prev_clk_en = 1'b0; prev_stall_from_alu = 1'b0;
    @(negedge clk);
    o_ce2 = clk_en;
  endtask

  initial begin
    vec[0]  = mk(1, F3_SW, 32'h100, 32'hDEADBEEF, 0, 3, 0, 1, 32'h100, 4'b1111, 32'hDEADBEEF, 1, PASS_WD, 0, 0, 0);
    vec[1]  = mk(1, F3_SB, 32'h203, 32'h000000A5, 0, 1, 0, 1, 32'h200, 4'b1000, 32'hA5A5A5A5, 1, PASS_WD, 0, 0, 0);
    vec[2]  = mk(1, F3_SH, 32'h102, 32'h1234BEEF, 0, 0, 0, 1, 32'h100, 4'b1100, 32'hBEEFBEEF, 1, PASS_WD, 0, 0, 0);
    vec[3]  = mk(0, F3_LB, 32'h002, 0, 32'h12F03456, 1, 0, 1, 32'h000, 4'b0100, 0, 1, 32'hFFFFFFF0, 1, 1, 0);
    vec[4]  = mk(0, F3_LBU, 32'h002, 0, 32'h12F03456, 1, 0, 1, 32'h000, 4'b0100, 0, 1, 32'h000000F0, 1, 1, 0);
    vec[5]  = mk(0, F3_LH, 32'h006, 0, 32'h80017FFF, 2, 0, 1, 32'h004, 4'b1100, 0, 1, 32'hFFFF8001, 1, 1, 0);
    vec[6]  = mk(0, F3_LHU, 32'h004, 0, 32'h80017FFF, 0, 0, 1, 32'h004, 4'b0011, 0, 1, 32'h00007FFF, 1, 1, 0);
    vec[7]  = mk(0, F3_LW, 32'h108, 0, 32'h89ABCDEF, 1, 0, 1, 32'h108, 4'b1111, 0, 1, 32'h89ABCDEF, 1, 1, 0);
    vec[8]  = mk(0, F3_LB, 32'h001, 0, 32'h00007F00, 0, 0, 1, 32'h000, 4'b0010, 0, 1, 32'h0000007F, 1, 1, 0);
    vec[9]  = mk(0, 3'b011, 32'h040, 0, 32'h0, 0, 0, 0, 0, 0, 0, 1, PASS_WD, 0, 0, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    vec[10] = mk(0, F3_LW, 32'h102, 0, 32'h0A0B0C0D, 0, 0, 0, 0, 0, 0, 1, PASS_WD, 0, 0, EXC_LD);
    vec[11] = mk(1, F3_SW, 32'h101, 32'h11111111, 0, 0, 0, 0, 0, 0, 0, 1, PASS_WD, 0, 0, EXC_ST);
`else
    vec[10] = mk(0, F3_LW, 32'h102, 0, 32'h0A0B0C0D, 0, 0, 1, 32'h100, 4'b1111, 0, 1, 32'h0A0B0C0D, 1, 1, 0);
    vec[11] = mk(1, F3_SW, 32'h101, 32'h11111111, 0, 0, 0, 1, 32'h100, 4'b1111, 32'h11111111, 1, PASS_WD, 0, 0, 0);
`endif
    vec[12] = mk(0, F3_LW, 32'h010, 0, 32'h00000001, 2, 1, 1, 32'h010, 4'b1111, 0, 0, 0, 0, 0, 0);

    // Reset state
    #12;
    chk("rst_req", {31'b0, dmem_req}, 0);
    chk("rst_be", {28'b0, dmem_be}, 0);
    chk("rst_clk_en", {31'b0, clk_en}, 0);
    chk("rst_rd_wdata", rd_wdata, 0);
    chk("rst_rd_w_en", {31'b0, rd_w_en}, 0);
    chk("rst_stall", {31'b0, stall}, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Table-driven accesses
    for (int k = 0; k < 13; k++) begin
      run_vec(vec[k]);
      chk($sformatf("v%0d_stall_arrive", k), {31'b0, o_stall0}, 1);
      chk($sformatf("v%0d_req", k), {31'b0, o_req}, {31'b0, vec[k].e_req});
      if (vec[k].e_req) begin
        chk($sformatf("v%0d_addr", k), o_addr, vec[k].e_addr);
        chk($sformatf("v%0d_be", k), {28'b0, o_be}, {28'b0, vec[k].e_be});
        chk($sformatf("v%0d_we", k), {31'b0, o_we}, {31'b0, vec[k].st});
        if (vec[k].st) chk($sformatf("v%0d_wdata", k), o_wd, vec[k].e_wd);
        if (vec[k].dly > 0) chk($sformatf("v%0d_held", k), {31'b0, o_held}, 1);
      end
      chk($sformatf("v%0d_timeout", k), {31'b0, o_tmo}, 0);
      chk($sformatf("v%0d_clk_en", k), {31'b0, o_ce}, {31'b0, vec[k].e_ce});
      chk($sformatf("v%0d_clk_en_pulse", k), {31'b0, o_ce2}, 0);
      if (!vec[k].fl) begin
        chk($sformatf("v%0d_rd_wdata", k), o_rdw, vec[k].e_rdw);
        chk($sformatf("v%0d_rd_valid", k), {31'b0, o_rdv}, {31'b0, vec[k].e_rdv});
        chk($sformatf("v%0d_rd_w_en", k), {31'b0, o_wen}, {31'b0, vec[k].e_wen});
        chk($sformatf("v%0d_exc", k), {28'b0, o_exc}, {28'b0, vec[k].e_exc});
      end
      if (o_tmo) begin
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
      end
    end

    // External stall while the load sits in DONE: no new request, bubble, then one result
    @(negedge clk);
    drive_mem(0, F3_LW, 32'h20, 0);
    @(negedge clk);
    chk("fs_req", {31'b0, dmem_req}, 1);
    dmem_ack = 1'b1; dmem_rdata = 32'h11223344; force_stall = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    chk("fs_stall_done", {31'b0, stall}, 1);
    chk("fs_req_done", {31'b0, dmem_req}, 0);
    repeat (2) @(negedge clk);
    chk("fs_bubble", {31'b0, clk_en}, 0);
    chk("fs_req_quiet", {31'b0, dmem_req}, 0);
    force_stall = 1'b0;
    @(negedge clk);
    chk("fs_clk_en", {31'b0, clk_en}, 1);
    chk("fs_rd_wdata", rd_wdata, 32'h11223344);
    prev_clk_en = 1'b0; prev_stall_from_alu = 1'b0;
    @(negedge clk);

    // Reset in the middle of a transaction drops the request at once
    drive_mem(0, F3_LW, 32'h30, 0);
    @(negedge clk);
    chk("mid_req", {31'b0, dmem_req}, 1);
    rstn = 1'b0;
    #1 chk("mid_rst_req", {31'b0, dmem_req}, 0);
    prev_clk_en = 1'b0; prev_stall_from_alu = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Non-memory instruction passes straight through; downstream stall holds outputs
    prev_opcode_type = '0; prev_opcode_type[OP_OP] = 1'b1;
    prev_stall_from_alu = 1'b0; prev_rd_wdata = 32'h0BADF00D; prev_rd_valid = 1'b1;
    prev_rd_w_en = 1'b1; prev_rd = 5'd7; prev_pc = 32'h400; prev_clk_en = 1'b1;
    #1 chk("alu_stall", {31'b0, stall}, 0);
    @(negedge clk);
    chk("alu_clk_en", {31'b0, clk_en}, 1);
    chk("alu_rd_wdata", rd_wdata, 32'h0BADF00D);
    chk("alu_rd", {27'b0, rd}, 7);
    chk("alu_pc", pc, 32'h400);
    chk("alu_rd_valid", {31'b0, rd_valid}, 1);
    prev_stall = 1'b1; prev_rd_wdata = 32'h12345678;
    @(negedge clk);
    chk("ps_clk_en_hold", {31'b0, clk_en}, 1);
    chk("ps_rd_wdata_hold", rd_wdata, 32'h0BADF00D);
    prev_stall = 1'b0; prev_clk_en = 1'b0;
    @(negedge clk);
    chk("alu_clk_en_drop", {31'b0, clk_en}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
